// File: rtl/pp_pipeline_accel_mac_pkg.sv
// Shared types and arithmetic helpers for the pre-processing MAC pipeline.
// The helpers work on a fixed 64-bit container so one set of functions serves every parameterisation.
package pp_pipeline_accel_mac_pkg;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic valid;
    logic acc_en;
    logic acc_clr;
  } ctl_t;

  typedef struct packed {
    logic signed [MAX_W:0] val;
    logic                  sat;
  } sat_t;

  function automatic int prod_width(input int a_width, input int b_width);
    return a_width + b_width + 2;
  endfunction

  function automatic logic signed [MAX_W:0] out_max(input int out_width);
    logic signed [MAX_W:0] one;
    one = 1;
    return (one <<< (out_width - 1)) - one;
  endfunction

  function automatic logic signed [MAX_W:0] out_min(input int out_width);
    logic signed [MAX_W:0] one;
    one = 1;
    return -(one <<< (out_width - 1));
  endfunction

  // One guard bit above the container keeps the half-LSB add from wrapping.
  function automatic logic signed [MAX_W:0] round_shift(input logic signed [MAX_W-1:0] x,
                                                        input int shift);
    logic signed [MAX_W:0] xe;
    logic signed [MAX_W:0] one;
    one = 1;
    xe  = {x[MAX_W-1], x};
    if (shift > 0) xe = xe + (one <<< (shift - 1));
    return xe >>> shift;
  endfunction

  function automatic sat_t saturate(input logic signed [MAX_W:0] r, input int out_width);
    sat_t                  res;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    hi      = out_max(out_width);
    lo      = out_min(out_width);
    res.sat = 1'b1;
    if (r > hi)      res.val = hi;
    else if (r < lo) res.val = lo;
    else begin
      res.val = r;
      res.sat = 1'b0;
    end
    return res;
  endfunction

  function automatic bit params_ok(input int a_width, input int b_width, input int acc_width,
                                   input int shift, input int out_width, input int num_stage);
    return (a_width >= 1) && (b_width >= 1) && (acc_width >= a_width + b_width + 1) &&
           (acc_width <= MAX_W) && (shift >= 0) && (shift < acc_width) &&
           (out_width >= 2) && (out_width <= acc_width - shift) && (num_stage >= 3);
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_mac_pipe_if.sv
// Sample/result bundle of the MAC pipeline. There is no backpressure: a sample is taken on every
// rising edge where ce=1 and in_valid=1; a result is present on every cycle where out_valid=1.
interface pp_pipeline_accel_mac_pipe_if #(
  parameter int A_WIDTH   = 12,
  parameter int B_WIDTH   = 9,
  parameter int OUT_WIDTH = 21
);
  logic                        in_valid;
  logic [A_WIDTH-1:0]          a;
  logic [B_WIDTH-1:0]          b;
  logic                        acc_en;
  logic                        acc_clr;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] p;
  logic                        sat_flag;

  modport master (output in_valid, a, b, acc_en, acc_clr,
                  input  out_valid, p, sat_flag);
  modport slave  (input  in_valid, a, b, acc_en, acc_clr,
                  output out_valid, p, sat_flag);
endinterface

// File: rtl/pp_pipeline_accel_mac_dsp_core.sv
// Operand, product and delay registers of the MAC, shaped to map onto a DSP block's A/B/M/P regs.
// Control bits ride alongside the product so every stage stays aligned under ce stalls.
module pp_pipeline_accel_mac_dsp_core
  import pp_pipeline_accel_mac_pkg::*;
#(
  parameter int A_WIDTH   = 12,
  parameter int B_WIDTH   = 9,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 1,
  parameter int ACC_WIDTH = 32,
  parameter int NUM_STAGE = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic [A_WIDTH-1:0]          a,
  input  logic [B_WIDTH-1:0]          b,
  input  logic                        acc_en,
  input  logic                        acc_clr,
  output logic signed [ACC_WIDTH-1:0] prod_out,
  output ctl_t                        ctl_out
);
  localparam int PW  = prod_width(A_WIDTH, B_WIDTH);
  localparam int DLY = NUM_STAGE - 3;

  logic [A_WIDTH-1:0]          a_q;
  logic [B_WIDTH-1:0]          b_q;
  ctl_t                        ctl_s1;
  ctl_t                        ctl_s2;
  logic signed [A_WIDTH:0]     a_ext;
  logic signed [B_WIDTH:0]     b_ext;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_s2;

  // Widening by one bit lets unsigned and signed operands share one signed multiplier.
  always_comb begin
    a_ext = {(A_SIGNED != 0) ? a_q[A_WIDTH-1] : 1'b0, a_q};
    b_ext = {(B_SIGNED != 0) ? b_q[B_WIDTH-1] : 1'b0, b_q};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      ctl_s1  <= '0;
      prod_s2 <= '0;
      ctl_s2  <= '0;
    end else if (ce) begin
      a_q     <= a;
      b_q     <= b;
      ctl_s1  <= '{valid: in_valid, acc_en: acc_en, acc_clr: acc_clr};
      prod_s2 <= ACC_WIDTH'(prod);
      ctl_s2  <= ctl_s1;
    end
  end

  generate
    if (DLY == 0) begin : g_no_delay
      assign prod_out = prod_s2;
      assign ctl_out  = ctl_s2;
    end else begin : g_delay
      logic signed [ACC_WIDTH-1:0] prod_dl [DLY];
      ctl_t                        ctl_dl  [DLY];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DLY; i++) begin
            prod_dl[i] <= '0;
            ctl_dl[i]  <= '0;
          end
        end else if (ce) begin
          prod_dl[0] <= prod_s2;
          ctl_dl[0]  <= ctl_s2;
          for (int i = 1; i < DLY; i++) begin
            prod_dl[i] <= prod_dl[i-1];
            ctl_dl[i]  <= ctl_dl[i-1];
          end
        end
      end

      assign prod_out = prod_dl[DLY-1];
      assign ctl_out  = ctl_dl[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/pp_pipeline_accel_mac_pipe.sv
// Parametrised multiply-accumulate for the pre-processing pipeline: DSP core followed by the
// accumulate, round-half-up shift and output saturation stage.
module pp_pipeline_accel_mac_pipe
  import pp_pipeline_accel_mac_pkg::*;
#(
  parameter int A_WIDTH   = 12,
  parameter int B_WIDTH   = 9,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 1,
  parameter int ACC_WIDTH = 32,
  parameter int SHIFT     = 0,
  parameter int OUT_WIDTH = 21,
  parameter int NUM_STAGE = 4
) (
  input logic                    clk,
  input logic                    reset_n,
  input logic                    ce,
  pp_pipeline_accel_mac_pipe_if.slave bus
);
  generate
    if (!params_ok(A_WIDTH, B_WIDTH, ACC_WIDTH, SHIFT, OUT_WIDTH, NUM_STAGE)) begin : g_bad_params
      $error("pp_pipeline_accel_mac_pipe: illegal parameter combination");
    end
  endgenerate

  logic signed [ACC_WIDTH-1:0] prod_d;
  ctl_t                        ctl_d;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [MAX_W:0]       rounded;
  sat_t                        sres;

  pp_pipeline_accel_mac_dsp_core #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .A_SIGNED  (A_SIGNED),
    .B_SIGNED  (B_SIGNED),
    .ACC_WIDTH (ACC_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_dsp_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .in_valid (bus.in_valid),
    .a        (bus.a),
    .b        (bus.b),
    .acc_en   (bus.acc_en),
    .acc_clr  (bus.acc_clr),
    .prod_out (prod_d),
    .ctl_out  (ctl_d)
  );

  // Anything other than "accumulate without clear" restarts the sum from this product.
  always_comb begin
    acc_next = (ctl_d.acc_en && !ctl_d.acc_clr) ? acc + prod_d : prod_d;
    rounded  = round_shift(MAX_W'(acc_next), SHIFT);
    sres     = saturate(rounded, OUT_WIDTH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc           <= '0;
      bus.p         <= '0;
      bus.sat_flag  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (ce) begin
      bus.out_valid <= ctl_d.valid;
      if (ctl_d.valid) begin
        acc          <= acc_next;
        bus.p        <= sres.val[OUT_WIDTH-1:0];
        bus.sat_flag <= sres.sat;
      end
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_mac_pipe.sv
// Bench for the MAC pipeline: a default build and a SHIFT=4 build share one stimulus stream and
// are both compared every cycle against an arithmetic model of sum-of-products, round and clamp.
module tb_pp_pipeline_accel_mac_pipe;
  localparam int AW  = 12;
  localparam int BW  = 9;
  localparam int OW  = 21;
  localparam int NS  = 4;
  localparam int SH1 = 4;
  localparam int EW  = 98;
  localparam longint OMAX = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (OW - 1));

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          acc_en = 1'b0;
  logic          acc_clr = 1'b0;

  pp_pipeline_accel_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus0 ();
  pp_pipeline_accel_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.a        = a;
  assign bus0.b        = b;
  assign bus0.acc_en   = acc_en;
  assign bus0.acc_clr  = acc_clr;
  assign bus1.in_valid = in_valid;
  assign bus1.a        = a;
  assign bus1.b        = b;
  assign bus1.acc_en   = acc_en;
  assign bus1.acc_clr  = acc_clr;

  pp_pipeline_accel_mac_pipe dut0 (.clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus0));
  pp_pipeline_accel_mac_pipe #(.SHIFT(SH1)) dut1 (.clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus1));

  // scoreboard
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap32(input longint x);
    logic [31:0] t;
    t = x[31:0];
    return longint'($signed(t));
  endfunction

  function automatic longint rnd(input longint x, input int s);
    if (s == 0) return x;
    return (x + (longint'(1) <<< (s - 1))) >>> s;
  endfunction

  function automatic longint clampv(input longint r);
    if (r > OMAX) return OMAX;
    if (r < OMIN) return OMIN;
    return r;
  endfunction

  // Each queue entry: {due enabled-edge count, p0, sat0, p1, sat1}.
  logic [EW-1:0] exp_q[$];
  int unsigned   en_cnt = 0;
  longint        m_acc = 0;
  logic          exp_ov = 1'b0;
  longint        exp_p0 = 0;
  longint        exp_p1 = 0;
  logic          exp_s0 = 1'b0;
  logic          exp_s1 = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    longint prod, r0, r1, c0, c1;
    logic [EW-1:0] item;
    if (!reset_n) begin
      exp_q.delete();
      en_cnt = 0; m_acc = 0; exp_ov = 1'b0;
      exp_p0 = 0; exp_p1 = 0; exp_s0 = 1'b0; exp_s1 = 1'b0;
    end else if (ce) begin
      en_cnt++;
      if (in_valid) begin
        prod = longint'(a) * longint'($signed(b));
        m_acc = (acc_en && !acc_clr) ? wrap32(m_acc + prod) : wrap32(prod);
        r0 = rnd(m_acc, 0);
        r1 = rnd(m_acc, SH1);
        c0 = clampv(r0);
        c1 = clampv(r1);
        exp_q.push_back({32'(en_cnt + NS - 1), 32'(c0), (c0 != r0), 32'(c1), (c1 != r1)});
      end
      if (exp_q.size() > 0 && exp_q[0][97:66] == en_cnt) begin
        item   = exp_q.pop_front();
        exp_ov = 1'b1;
        exp_p0 = longint'($signed(item[65:34]));
        exp_s0 = item[33];
        exp_p1 = longint'($signed(item[32:1]));
        exp_s1 = item[0];
      end else begin
        exp_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("ov0",  bus0.out_valid, exp_ov);
    check("p0",   bus0.p,         exp_p0);
    check("sat0", bus0.sat_flag,  exp_s0);
    check("ov1",  bus1.out_valid, exp_ov);
    check("p1",   bus1.p,         exp_p1);
    check("sat1", bus1.sat_flag,  exp_s1);
  end

  // driver tasks
  task automatic drive(input int va, input int vb, input bit en, input bit clr);
    @(negedge clk);
    in_valid = 1'b1;
    a = AW'(va);
    b = BW'(vb);
    acc_en = en;
    acc_clr = clr;
  endtask

  task automatic get_result(output longint p0, output logic s0, output longint p1, output logic s1);
    bit found;
    found = 1'b0;
    p0 = 0; p1 = 0; s0 = 1'b0; s1 = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = AW'($urandom_range(0, 4095));
      b = BW'($urandom_range(0, 511));
      acc_en = 1'($urandom_range(0, 1));
      acc_clr = 1'($urandom_range(0, 1));
      #1;
      if (bus0.out_valid) begin
        found = 1'b1;
        p0 = bus0.p; s0 = bus0.sat_flag;
        p1 = bus1.p; s1 = bus1.sat_flag;
      end
    end
    if (!found) check("result_timeout", 0, 1);
  endtask

  task automatic expect0(input string tag, input longint ep, input logic es);
    longint p0, p1;
    logic s0, s1;
    get_result(p0, s0, p1, s1);
    check({tag, "_p"}, p0, ep);
    check({tag, "_sat"}, s0, es);
  endtask

  task automatic expect1(input string tag, input longint ep);
    longint p0, p1;
    logic s0, s1;
    get_result(p0, s0, p1, s1);
    check(tag, p1, ep);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ov",  bus0.out_valid, 0);
    check("rst_p",   bus0.p, 0);
    check("rst_sat", bus0.sat_flag, 0);
    reset_n = 1'b1;

    drive(4095, -256, 1'b0, 1'b0);
    expect0("single", -1048320, 1'b0);

    drive(100, 10, 1'b1, 1'b1);
    drive(100, 10, 1'b1, 1'b0);
    drive(100, 10, 1'b1, 1'b0);
    drive(1, 1, 1'b1, 1'b1);
    expect0("acc1", 1000, 1'b0);
    expect0("acc2", 2000, 1'b0);
    expect0("acc3", 3000, 1'b0);
    expect0("acc_clr", 1, 1'b0);

    drive(4095, 255, 1'b1, 1'b1);
    drive(4095, 255, 1'b1, 1'b0);
    drive(4095, -256, 1'b1, 1'b1);
    drive(4095, -256, 1'b1, 1'b0);
    expect0("satp_a", 1044225, 1'b0);
    expect0("satp_b", 1048575, 1'b1);
    expect0("satn_a", -1048320, 1'b0);
    expect0("satn_b", -1048576, 1'b1);

    drive(24, 1, 1'b0, 1'b0);
    expect1("sh_24", 2);
    drive(23, 1, 1'b0, 1'b0);
    expect1("sh_23", 1);
    drive(24, -1, 1'b0, 1'b0);
    expect1("sh_m24", -1);
    drive(40, -1, 1'b0, 1'b0);
    expect1("sh_m40", -2);

    drive(7, 3, 1'b0, 1'b0);
    drive(5, -2, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    ce = 1'b0;
    repeat (3) @(negedge clk);
    ce = 1'b1;
    expect0("stall_a", 21, 1'b0);
    expect0("stall_b", -10, 1'b0);

    drive(100, 50, 1'b1, 1'b1);
    expect0("pre_rst", 5000, 1'b0);
    drive(1, 1, 1'b1, 1'b0);
    drive(1, 1, 1'b1, 1'b0);
    @(posedge clk);
    in_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_ov0", bus0.out_valid, 0);
    check("mid_rst_p0",  bus0.p, 0);
    check("mid_rst_ov1", bus1.out_valid, 0);
    check("mid_rst_p1",  bus1.p, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(3, 2, 1'b1, 1'b0);
    expect0("post_rst", 6, 1'b0);

    repeat (400) begin
      @(negedge clk);
      ce       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      a        = AW'($urandom_range(0, 4095));
      b        = BW'($urandom_range(0, 511));
      acc_en   = 1'($urandom_range(0, 1));
      acc_clr  = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    ce = 1'b1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pp_pipeline_accel_mac_pipe.md
Name: pp_pipeline_accel_mac_pipe

Overview:
- Parametrised successor to the fixed-width 12x9 DSP multiplier used in the pre-processing pipeline.
- Takes operand widths and signedness as parameters, plus configurable pipeline depth.
- Adds per-sample valid tracking, an optional accumulate mode with clear, round-half-up right shift, and saturation to the output width.
- Sits between the pixel-format stages and the normalisation/colour-matrix stages. These need sum-of-products with clamped results.

Parameters:
- A_WIDTH, 12: width of operand a.
- B_WIDTH, 9: width of operand b.
- A_SIGNED, 0: 1 means a is two's complement; 0 means unsigned.
- B_SIGNED, 1: 1 means b is two's complement; 0 means unsigned.
- ACC_WIDTH, 32: signed accumulator width. Must be >= A_WIDTH+B_WIDTH+1.
- SHIFT, 0: right shift applied to the accumulator before output. Range 0..ACC_WIDTH-1.
- OUT_WIDTH, 21: signed output width. Must be <= ACC_WIDTH-SHIFT.
- NUM_STAGE, 4: total latency in enabled cycles. Must be >= 3.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; low freezes all state
- in_valid  in  1  a/b/acc_en/acc_clr carry a sample this cycle
- a  in  A_WIDTH  operand a
- b  in  B_WIDTH  operand b
- acc_en  in  1  add this product to the running accumulator
- acc_clr  in  1  start a new sum with this product (ignored when acc_en=0)
- out_valid  out  1  p holds a new result
- p  out  OUT_WIDTH  rounded, saturated result (signed)
- sat_flag  out  1  p was clamped for this result

Behaviour:
- Reset: while reset_n=0, all registers clear asynchronously: operands, product, delay stages, valid bits, accumulator, p=0, out_valid=0, sat_flag=0. Release is synchronous to clk.
- Assertion mid-operation discards all in-flight samples and the accumulator. The first result after release comes from a sample accepted after release.
- Stall: ce=0 freezes every register, including the valid bits, acc, p, out_valid and sat_flag. There is no drop and no duplication. Latency is counted in ce=1 cycles only.
- Stage 1: register a, b, in_valid, acc_en, acc_clr.
- Operand extension: each operand is extended by one bit, sign-extended if its *_SIGNED parameter is 1, else zero-extended. The product is then signed, (A_WIDTH+1)+(B_WIDTH+1) bits, sign-extended to ACC_WIDTH.
- Stage 2: register the product. All control bits travel alongside the data in matching registers.
- Stages 3 to NUM_STAGE-1: pure delay registers for product and controls. There are NUM_STAGE-3 of them.
- Final stage (stage NUM_STAGE), when the delayed valid=1:
  - acc_en=0: acc <= prod (pass-through).
  - acc_en=1, acc_clr=1: acc <= prod.
  - acc_en=1, acc_clr=0: acc <= acc + prod, modulo 2^ACC_WIDTH. Accumulator overflow is the user's responsibility.
  - Output path: r = (acc_next + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (arithmetic shift; round half toward +inf).
  - p <= clamp(r, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1).
  - sat_flag <= 1 if a clamp occurred, else 0.
  - out_valid <= 1.
- Final stage, when the delayed valid=0: acc, p and sat_flag hold; out_valid <= 0.
- Latency: a sample accepted at edge k (ce=1, in_valid=1) produces out_valid=1 with p after edge k+NUM_STAGE-1. Visible result is NUM_STAGE cycles from input presentation.
- Throughput: one sample per enabled cycle; back-to-back accumulation needs no bubbles.
- in_valid=0 samples never touch acc, whatever acc_en and acc_clr are.
- Rounding add uses ACC_WIDTH+1 bits so it cannot wrap.

Decomposition:
- Shared package pp_pipeline_accel_mac_pkg holds:
  - localparam helpers: product width, maximum and minimum for OUT_WIDTH.
  - round_shift function.
  - saturate function.
  - elaboration-time parameter legality checks.
- One sub-module: pp_pipeline_accel_mac_dsp_core.
  - Contains stage 1, stage 2 and the delay chain with control sideband.
  - Keeps the DSP48 mapping (A/B/M/P registers) isolated from the accumulate/round/saturate tail in the top module.

Test Plan:
- Default parameters, a=4095, b=-256 (9'h100), acc_en=0, one valid sample -> out_valid high for exactly one cycle, 4 cycles after presentation, p=-1048320, sat_flag=0.
- Accumulate three samples a=100, b=10 back to back, acc_clr=1 on the first only -> p=1000, 2000, 3000 on consecutive cycles. A fourth sample a=1, b=1 with acc_clr=1 -> p=1.
- Saturation: acc_en=1, two samples a=4095, b=255 -> first p=1044225, sat_flag=0. Second (acc=2088450) -> p=1048575, sat_flag=1. With b=-256 twice -> p=-1048576, sat_flag=1.
- SHIFT=4 build:
  - a=24, b=1 -> p=2.
  - a=23, b=1 -> p=1.
  - a=24, b=-1 -> p=-1 (-1.5 rounds up).
  - a=40, b=-1 -> p=-2 (-2.5 rounds up).
- Stall: ce=0 for 3 cycles while two samples are in flight -> outputs frozen. Results emerge in order with unchanged values, delayed exactly 3 cycles. No extra out_valid.
- Reset: reset_n pulsed low asynchronously, mid-clock, with 2 samples in flight and acc=5000 -> p=0, out_valid=0 immediately. A sample a=3, b=2 with acc_en=1, acc_clr=0 after release -> p=6.
